// File: rtl/perf_stats_pkg.sv
// Shared definitions for the performance statistics tracker: readout field
// indices and the saturating adder used by every counter.
package perf_stats_pkg;

    localparam logic [2:0] FLD_READS     = 3'd0;
    localparam logic [2:0] FLD_WRITES    = 3'd1;
    localparam logic [2:0] FLD_COMPLETED = 3'd2;
    localparam logic [2:0] FLD_LAT_SUM   = 3'd3;
    localparam logic [2:0] FLD_LAT_MIN   = 3'd4;
    localparam logic [2:0] FLD_LAT_MAX   = 3'd5;
    localparam logic [2:0] FLD_OUTSTAND  = 3'd6;
    localparam logic [2:0] FLD_TOTAL     = 3'd7;
    localparam int         NUM_FLD       = 8;

    // Adds two values and clamps the result to the all-ones value of a w-bit field (w <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [63:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (sum > {1'b0, lim}) ? lim : sum[63:0];
    endfunction

endpackage

// File: rtl/perf_stats_channel.sv
// One request channel: outstanding-tag table with issue timestamps plus the
// saturating statistics counters and sticky protocol error flags.
module perf_stats_channel
    import perf_stats_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 32,
    parameter int CYC_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CYC_W-1:0] global_cycle,
    input  logic             req_fire,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             resp_fire,
    input  logic [TAG_W-1:0] resp_tag,
    input  logic             clear,
    output logic [CNT_W-1:0] reads,
    output logic [CNT_W-1:0] writes,
    output logic [CNT_W-1:0] completed,
    output logic [CNT_W-1:0] lat_sum,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max,
    output logic [CNT_W-1:0] total_reqs,
    output logic [TAG_W:0]   outstanding,
    output logic             err_dup,
    output logic             err_orphan
);

    localparam int DEPTH = 2 ** TAG_W;

    logic             valid [DEPTH];
    logic [CYC_W-1:0] issue [DEPTH];

    logic             resp_hit, resp_orphan, req_dup, req_new;
    logic [CYC_W-1:0] lat_raw;
    logic [CNT_W-1:0] lat;

    logic [CNT_W-1:0] reads_n, writes_n, completed_n, lat_sum_n, lat_min_n, lat_max_n, total_n;
    logic [TAG_W:0]   outstanding_n;
    logic             err_dup_n, err_orphan_n;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        return CNT_W'(sat_add(64'(a), 64'(b), CNT_W));
    endfunction

    // The response sees the pre-cycle table, so a same-tag request in the
    // same cycle re-allocates a just-freed entry rather than duplicating it.
    always_comb begin
        resp_hit    = resp_fire && valid[resp_tag];
        resp_orphan = resp_fire && !valid[resp_tag];
        req_dup     = req_fire && valid[req_tag] && !(resp_hit && (resp_tag == req_tag));
        req_new     = req_fire && !req_dup;
        lat_raw     = global_cycle - issue[resp_tag];
        lat         = CNT_W'(sat_add(64'(lat_raw), 64'd0, CNT_W));
    end

    always_comb begin
        reads_n       = clear ? '0 : reads;
        writes_n      = clear ? '0 : writes;
        completed_n   = clear ? '0 : completed;
        lat_sum_n     = clear ? '0 : lat_sum;
        lat_min_n     = clear ? '1 : lat_min;
        lat_max_n     = clear ? '0 : lat_max;
        total_n       = clear ? '0 : total_reqs;
        err_dup_n     = clear ? 1'b0 : err_dup;
        err_orphan_n  = clear ? 1'b0 : err_orphan;
        outstanding_n = outstanding;

        if (req_fire) begin
            total_n = bump(total_n, CNT_W'(1));
            if (req_rd) reads_n  = bump(reads_n, CNT_W'(1));
            if (req_wr) writes_n = bump(writes_n, CNT_W'(1));
        end
        if (resp_hit) begin
            completed_n = bump(completed_n, CNT_W'(1));
            lat_sum_n   = bump(lat_sum_n, lat);
            if (lat < lat_min_n) lat_min_n = lat;
            if (lat > lat_max_n) lat_max_n = lat;
        end

        if (req_new && !resp_hit)      outstanding_n = outstanding + (TAG_W+1)'(1);
        else if (resp_hit && !req_new) outstanding_n = outstanding - (TAG_W+1)'(1);

        err_dup_n    = err_dup_n | req_dup;
        err_orphan_n = err_orphan_n | resp_orphan;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) valid[i] <= 1'b0;
            reads       <= '0;
            writes      <= '0;
            completed   <= '0;
            lat_sum     <= '0;
            lat_min     <= '1;
            lat_max     <= '0;
            total_reqs  <= '0;
            outstanding <= '0;
            err_dup     <= 1'b0;
            err_orphan  <= 1'b0;
        end else begin
            if (resp_hit) valid[resp_tag] <= 1'b0;
            if (req_fire) valid[req_tag]  <= 1'b1;
            reads       <= reads_n;
            writes      <= writes_n;
            completed   <= completed_n;
            lat_sum     <= lat_sum_n;
            lat_min     <= lat_min_n;
            lat_max     <= lat_max_n;
            total_reqs  <= total_n;
            outstanding <= outstanding_n;
            err_dup     <= err_dup_n;
            err_orphan  <= err_orphan_n;
        end
    end

    // Timestamps are only meaningful while valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (req_fire) issue[req_tag] <= global_cycle;
    end

endmodule

// File: rtl/perf_stats_tracker.sv
// Multi-channel request latency / throughput tracker with a registered
// (channel, field) readout port.
module perf_stats_tracker
    import perf_stats_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 32,
    parameter int CYC_W  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CYC_W-1:0]        global_cycle,
    input  logic [NUM_CH-1:0]       req_fire,
    input  logic [NUM_CH-1:0]       req_rd,
    input  logic [NUM_CH-1:0]       req_wr,
    input  logic [NUM_CH*TAG_W-1:0] req_tag,
    input  logic [NUM_CH-1:0]       resp_fire,
    input  logic [NUM_CH*TAG_W-1:0] resp_tag,
    input  logic                    clear,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
    input  logic [2:0]              rd_field,
    output logic [CNT_W-1:0]        rd_data,
    output logic [NUM_CH-1:0]       err_dup,
    output logic [NUM_CH-1:0]       err_orphan
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SLOTS = 2 ** CH_W;

    logic [CNT_W-1:0] fld [SLOTS][NUM_FLD];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] reads, writes, completed, lat_sum, lat_min, lat_max, total_reqs;
        logic [TAG_W:0]   outstanding;

        perf_stats_channel #(
            .TAG_W(TAG_W),
            .CNT_W(CNT_W),
            .CYC_W(CYC_W)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .global_cycle(global_cycle),
            .req_fire    (req_fire[c]),
            .req_rd      (req_rd[c]),
            .req_wr      (req_wr[c]),
            .req_tag     (req_tag[c*TAG_W +: TAG_W]),
            .resp_fire   (resp_fire[c]),
            .resp_tag    (resp_tag[c*TAG_W +: TAG_W]),
            .clear       (clear),
            .reads       (reads),
            .writes      (writes),
            .completed   (completed),
            .lat_sum     (lat_sum),
            .lat_min     (lat_min),
            .lat_max     (lat_max),
            .total_reqs  (total_reqs),
            .outstanding (outstanding),
            .err_dup     (err_dup[c]),
            .err_orphan  (err_orphan[c])
        );

        assign fld[c][FLD_READS]     = reads;
        assign fld[c][FLD_WRITES]    = writes;
        assign fld[c][FLD_COMPLETED] = completed;
        assign fld[c][FLD_LAT_SUM]   = lat_sum;
        assign fld[c][FLD_LAT_MIN]   = lat_min;
        assign fld[c][FLD_LAT_MAX]   = lat_max;
        assign fld[c][FLD_OUTSTAND]  = CNT_W'(outstanding);
        assign fld[c][FLD_TOTAL]     = total_reqs;
    end

    // Selects beyond the last real channel read back as zero.
    for (genvar c = NUM_CH; c < SLOTS; c++) begin : g_pad
        for (genvar f = 0; f < NUM_FLD; f++) begin : g_fld
            assign fld[c][f] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data <= '0;
        else       rd_data <= fld[rd_ch][rd_field];
    end

endmodule

// File: tb/tb_perf_stats_tracker.sv
// Directed self-checking bench for perf_stats_tracker; a second instance with
// 8-bit counters exercises latency and counter saturation.
module tb_perf_stats_tracker;

    localparam int FR = 0, FW = 1, FC = 2, FS = 3, FMIN = 4, FMAX = 5, FO = 6, FT = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] global_cycle;
    logic [3:0]  req_fire, req_rd, req_wr, resp_fire;
    logic [15:0] req_tag, resp_tag;
    logic        clear;
    logic [1:0]  rd_ch;
    logic [2:0]  rd_field;
    logic [31:0] rd_data;
    logic [7:0]  rd_data8;
    logic [3:0]  err_dup, err_orphan, err_dup8, err_orphan8;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] v;
    logic [7:0]  v8;

    always #5 clk = ~clk;

    perf_stats_tracker #(.NUM_CH(4), .TAG_W(4), .CNT_W(32), .CYC_W(64)) dut (
        .clk(clk), .reset(reset), .global_cycle(global_cycle),
        .req_fire(req_fire), .req_rd(req_rd), .req_wr(req_wr), .req_tag(req_tag),
        .resp_fire(resp_fire), .resp_tag(resp_tag), .clear(clear),
        .rd_ch(rd_ch), .rd_field(rd_field), .rd_data(rd_data),
        .err_dup(err_dup), .err_orphan(err_orphan)
    );

    perf_stats_tracker #(.NUM_CH(4), .TAG_W(4), .CNT_W(8), .CYC_W(64)) dut8 (
        .clk(clk), .reset(reset), .global_cycle(global_cycle),
        .req_fire(req_fire), .req_rd(req_rd), .req_wr(req_wr), .req_tag(req_tag),
        .resp_fire(resp_fire), .resp_tag(resp_tag), .clear(clear),
        .rd_ch(rd_ch), .rd_field(rd_field), .rd_data(rd_data8),
        .err_dup(err_dup8), .err_orphan(err_orphan8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        req_fire  = '0;
        req_rd    = '0;
        req_wr    = '0;
        resp_fire = '0;
        clear     = 1'b0;
    endtask

    task automatic step(input logic [63:0] cyc);
        global_cycle = cyc;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic req(input int ch, input int tag, input bit rd, input bit wr);
        req_fire[ch]         = 1'b1;
        req_rd[ch]           = rd;
        req_wr[ch]           = wr;
        req_tag[ch*4 +: 4]   = 4'(tag);
    endtask

    task automatic resp(input int ch, input int tag);
        resp_fire[ch]        = 1'b1;
        resp_tag[ch*4 +: 4]  = 4'(tag);
    endtask

    task automatic rd(input int ch, input int f);
        rd_ch    = 2'(ch);
        rd_field = 3'(f);
        @(posedge clk);
        #1;
        v  = rd_data;
        v8 = rd_data8;
    endtask

    task automatic chk_fld(input string tag, input int ch, input int f, input logic [63:0] exp);
        rd(ch, f);
        check(tag, 64'(v), exp);
    endtask

    initial begin
        idle();
        global_cycle = '0;
        req_tag  = '0;
        resp_tag = '0;
        rd_ch    = '0;
        rd_field = '0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_data", 64'(rd_data), 64'd0);
        reset = 1'b0;
        chk_fld("reset_lat_min", 0, FMIN, 64'hFFFF_FFFF);
        chk_fld("reset_outstanding", 1, FO, 0);
        chk_fld("reset_total", 2, FT, 0);
        check("reset_err_dup", 64'(err_dup), 0);
        check("reset_err_orphan", 64'(err_orphan), 0);

        // single read transaction on ch0
        req(0, 3, 1, 0); step(100);
        chk_fld("ch0_outstanding_pending", 0, FO, 1);
        resp(0, 3); step(117);
        chk_fld("ch0_completed", 0, FC, 1);
        chk_fld("ch0_lat_sum", 0, FS, 17);
        chk_fld("ch0_lat_min", 0, FMIN, 17);
        chk_fld("ch0_lat_max", 0, FMAX, 17);
        chk_fld("ch0_reads", 0, FR, 1);
        chk_fld("ch0_outstanding", 0, FO, 0);
        chk_fld("ch0_total", 0, FT, 1);

        // two out-of-order writes on ch1
        req(1, 0, 0, 1); step(10);
        req(1, 1, 0, 1); step(11);
        resp(1, 1); step(15);
        resp(1, 0); step(30);
        chk_fld("ch1_lat_min", 1, FMIN, 4);
        chk_fld("ch1_lat_max", 1, FMAX, 20);
        chk_fld("ch1_lat_sum", 1, FS, 24);
        chk_fld("ch1_writes", 1, FW, 2);
        chk_fld("ch1_reads", 1, FR, 0);

        // orphan response and duplicate request on ch2
        resp(2, 5); step(40);
        check("ch2_err_orphan", 64'(err_orphan), 64'b0100);
        chk_fld("ch2_completed", 2, FC, 0);
        req(2, 5, 1, 0); step(41);
        req(2, 5, 1, 0); step(42);
        check("ch2_err_dup", 64'(err_dup), 64'b0100);
        chk_fld("ch2_outstanding", 2, FO, 1);
        chk_fld("ch2_total", 2, FT, 2);

        // same-tag request and response in one cycle on ch0
        req(0, 7, 1, 0); step(50);
        req(0, 7, 1, 0); resp(0, 7); step(60);
        chk_fld("ch0_same_lat_min", 0, FMIN, 10);
        chk_fld("ch0_same_outstanding", 0, FO, 1);
        check("ch0_same_no_dup", 64'(err_dup[0]), 0);
        resp(0, 7); step(65);
        chk_fld("ch0_reissue_lat_min", 0, FMIN, 5);
        chk_fld("ch0_reissue_lat_sum", 0, FS, 32);
        chk_fld("ch0_reissue_completed", 0, FC, 3);
        chk_fld("ch0_reissue_outstanding", 0, FO, 0);

        // timestamp wrap and latency saturation on ch3
        req(3, 2, 1, 0); step(64'hFFFF_FFFF_FFFF_FFFD);
        resp(3, 2); step(64'd2);
        chk_fld("ch3_wrap_lat", 3, FMAX, 5);
        req(3, 9, 1, 0); step(1000);
        resp(3, 9); step(1300);
        chk_fld("ch3_lat_max_300", 3, FMAX, 300);
        check("ch3_cnt8_lat_max_sat", 64'(v8), 255);
        chk_fld("ch3_lat_sum_305", 3, FS, 305);
        check("ch3_cnt8_lat_sum_sat", 64'(v8), 255);

        // clear coinciding with a new read request on ch3
        req(3, 4, 1, 0); step(1400);
        clear = 1'b1; req(3, 6, 1, 0); step(1401);
        chk_fld("clear_reads", 3, FR, 1);
        chk_fld("clear_total", 3, FT, 1);
        chk_fld("clear_lat_min", 3, FMIN, 64'hFFFF_FFFF);
        chk_fld("clear_completed", 3, FC, 0);
        chk_fld("clear_outstanding", 3, FO, 2);
        chk_fld("clear_other_ch", 0, FC, 0);
        check("clear_err_dup", 64'(err_dup), 0);
        check("clear_err_orphan", 64'(err_orphan), 0);

        // reset mid-operation discards outstanding entries
        reset = 1'b1; step(1500);
        reset = 1'b0;
        resp(3, 4); step(1501);
        check("post_reset_orphan", 64'(err_orphan), 64'b1000);
        chk_fld("post_reset_outstanding", 3, FO, 0);
        chk_fld("post_reset_completed", 3, FC, 0);

        // all channels active in the same cycles
        for (int c = 0; c < 4; c++) req(c, 1, 1, 0);
        step(500);
        for (int c = 0; c < 4; c++) resp(c, 1);
        step(503);
        for (int c = 0; c < 4; c++) begin
            chk_fld($sformatf("all_ch%0d_lat_sum", c), c, FS, 3);
            chk_fld($sformatf("all_ch%0d_outstanding", c), c, FO, 0);
        end

        // counter saturation in the 8-bit instance
        for (int i = 0; i < 260; i++) begin
            req(0, i % 16, 1, 0);
            step(64'(600 + i));
        end
        chk_fld("sat_reads_cnt32", 0, FR, 261);
        check("sat_reads_cnt8", 64'(v8), 255);
        chk_fld("sat_total_cnt32", 0, FT, 261);
        check("sat_total_cnt8", 64'(v8), 255);
        chk_fld("sat_outstanding", 0, FO, 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
